fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage and consumer of the branch/jump decision. Holds the program counter, issues word fetches to instruction memory over a req/ready handshake, and presents fetched instructions with their PC to decode. On `jump_branch_enable` from the execute-stage jump/branch logic it flushes all fetched-but-unconsumed instructions, squashes any outstanding fetch, and restarts fetching at the target.

## Interface
- `RESET_ADDRESS`, 32'h0000_0000, PC of the first fetch after reset.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `jump_branch_enable`  in  1  redirect request, valid for the cycle it is high.
- `jump_branch_address`  in  32  redirect target, sampled when `jump_branch_enable`=1.
- `stall`  in  1  decode cannot accept the instruction this cycle.
- `mem_req`  out  1  fetch request outstanding.
- `mem_address`  out  32  word address of the outstanding fetch.
- `mem_ready`  in  1  fetch completes this cycle; `mem_data` valid.
- `mem_data`  in  32  fetched instruction word.
- `instruction`  out  32  instruction to decode.
- `pc`  out  32  address of `instruction`.
- `instruction_valid`  out  1  `instruction`/`pc` valid.
- `address_misaligned`  out  1  one-cycle pulse: redirect target not word-aligned.

## Operation
- Registers: `fetch_pc`, output register (instruction, pc, valid), one-entry skid register (instruction, pc, valid), pending target, FSM.
- FSM states: IDLE (`mem_req`=0), REQUEST (`mem_req`=1, `mem_address`=`fetch_pc`), SQUASH (`mem_req`=1, address held, response to be discarded). `mem_req` decoded from state.
- Memory protocol: once `mem_req` is high, `mem_address` stays stable until a cycle with `mem_ready`=1; that cycle completes the fetch. `mem_ready` while `mem_req`=0 is ignored.
- Consume: decode takes the output register in any cycle with `instruction_valid`=1 and `stall`=0.
- IDLE -> REQUEST when skid empty (or emptied this cycle).
- REQUEST, `mem_ready`=1, no redirect: `fetch_pc` += 4 (mod 2^32, wraps). Data goes to output register if empty or consumed this cycle, else to skid. Skid full afterward -> IDLE, else stay REQUEST (back-to-back fetch).
- Skid drain: when output consumed and skid valid, skid moves to output; a response arriving the same cycle goes to skid.
- Redirect (`jump_branch_enable`=1), priority over `stall` and responses: output and skid valid cleared next cycle; target = {`jump_branch_address`[31:2], 2'b00}; `address_misaligned` pulses next cycle if `jump_branch_address`[1:0]≠0.
  - IDLE, or REQUEST with `mem_ready`=1: response (if any) discarded, `fetch_pc` <= target, -> REQUEST.
  - REQUEST with `mem_ready`=0: pending <= target, -> SQUASH.
  - SQUASH: pending <= target (latest redirect wins); -> REQUEST at `fetch_pc` <= pending on `mem_ready`, data discarded.
- SQUASH with `mem_ready`=1 and no new redirect: discard data, `fetch_pc` <= pending, -> REQUEST.
- Reset: state IDLE, `fetch_pc`=`RESET_ADDRESS`, all valids 0, `mem_req`=0, `mem_address`=`RESET_ADDRESS`, `instruction`=0, `pc`=0, `address_misaligned`=0. Reset mid-fetch abandons it; a later `mem_ready` for it is ignored (state IDLE).

## Timing
- Reset released before edge 0: IDLE in cycle 0, `mem_req`=1 with `RESET_ADDRESS` in cycle 1.
- Fetch latency: `mem_ready` in cycle N -> `instruction_valid` in N+1 (output free) with `pc` = fetched address.
- Zero-wait memory, no stall: one instruction per cycle, PCs +4.
- Redirect in cycle N: `instruction_valid`=0 in N+1; first fetch of target in N+1 (IDLE or completing REQUEST), or in M+1 after completing squashed fetch in cycle M.
- Max two fetched-unconsumed instructions (output + skid); no fetch issued while both are full.

## Test plan
- Reset, `mem_ready` always 1, `stall`=0: `mem_address` 0x0,0x4,0x8 on cycles 1,2,3; `instruction_valid` from cycle 2, `pc` tracks with one-cycle lag.
- `stall`=1 for 5 cycles during streaming: output holds, skid fills, `mem_req` drops, no instruction lost or duplicated; order preserved on release.
- Redirect to 0x100 with fetch outstanding (`mem_ready`=0 for 3 cycles): address held until ready, data discarded, next `mem_address`=0x100, no stale `instruction_valid`.
- Two redirects (0x200 then 0x300) during SQUASH: fetch resumes at 0x300 only.
- Redirect to 0x102 with `stall`=1 and output+skid full: both flushed, `address_misaligned` one-cycle pulse, next fetch 0x100.
- `fetch_pc`=0xFFFF_FFFC: next fetch 0x0000_0000; reset asserted mid-fetch: `mem_req`=0, outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ready fetch from instruction memory, a two-deep
// output/skid buffer toward decode, and redirect/flush handling for jumps and branches.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_branch_enable,
  input  logic [31:0] jump_branch_address,
  input  logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instruction_valid,
  output logic        address_misaligned
);

  typedef enum logic [1:0] {StIdle, StRequest, StSquash} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic        misaligned_q, misaligned_d;

  logic        consume;
  logic        out_free;
  logic        resp;
  logic [31:0] target;

  assign consume  = out_valid_q & ~stall;
  assign out_free = ~out_valid_q | consume;
  assign resp     = (state_q == StRequest) & mem_ready;
  assign target   = {jump_branch_address[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_d    = pending_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_valid_d  = out_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    misaligned_d = 1'b0;

    if (jump_branch_enable) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      misaligned_d = |jump_branch_address[1:0];
      unique case (state_q)
        StIdle: begin
          fetch_pc_d = target;
          state_d    = StRequest;
        end
        StRequest, StSquash: begin
          // A fetch completing now can be abandoned; otherwise its response must be eaten.
          if (mem_ready) begin
            fetch_pc_d = target;
            state_d    = StRequest;
          end else begin
            pending_d = target;
            state_d   = StSquash;
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
      if (out_free) begin
        if (skid_valid_q) begin
          out_instr_d  = skid_instr_q;
          out_pc_d     = skid_pc_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b0;
        end
      end

      if (resp) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        if (out_free && !skid_valid_q) begin
          out_instr_d = mem_data;
          out_pc_d    = fetch_pc_q;
          out_valid_d = 1'b1;
        end else begin
          skid_instr_d = mem_data;
          skid_pc_d    = fetch_pc_q;
          skid_valid_d = 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (!skid_valid_d) state_d = StRequest;
        end
        StRequest: begin
          if (mem_ready) state_d = skid_valid_d ? StIdle : StRequest;
        end
        StSquash: begin
          if (mem_ready) begin
            fetch_pc_d = pending_q;
            state_d    = StRequest;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_ADDRESS;
      pending_q    <= RESET_ADDRESS;
      out_instr_q  <= 32'h0;
      out_pc_q     <= 32'h0;
      out_valid_q  <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      skid_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_valid_q  <= out_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign mem_req            = (state_q != StIdle);
  assign mem_address        = fetch_pc_q;
  assign instruction        = out_instr_q;
  assign pc                 = out_pc_q;
  assign instruction_valid  = out_valid_q;
  assign address_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model plus an in-order scoreboard of
// fetched instructions that must reach decode.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump_branch_enable;
  logic [31:0] jump_branch_address;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_address;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instruction_valid;
  logic        address_misaligned;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5EED_C0DE;
  endfunction

  assign mem_data = mem_word(mem_address);

  fetch_unit #(.RESET_ADDRESS(32'h0000_0000)) dut (
    .clk                (clk),
    .reset              (reset),
    .jump_branch_enable (jump_branch_enable),
    .jump_branch_address(jump_branch_address),
    .stall              (stall),
    .mem_req            (mem_req),
    .mem_address        (mem_address),
    .mem_ready          (mem_ready),
    .mem_data           (mem_data),
    .instruction        (instruction),
    .pc                 (pc),
    .instruction_valid  (instruction_valid),
    .address_misaligned (address_misaligned)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] exp_fetch;
  logic [31:0] squash_addr;
  logic        exp_req;
  logic        discard;
  logic        exp_mis;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    check_eq({tag, "_mem_address"}, mem_address, 32'h0);
    check_eq({tag, "_valid"}, 32'(instruction_valid), 32'h0);
    check_eq({tag, "_instruction"}, instruction, 32'h0);
    check_eq({tag, "_pc"}, pc, 32'h0);
    check_eq({tag, "_misaligned"}, 32'(address_misaligned), 32'h0);
  endtask

  // Called at a falling edge: check current outputs, then drive this cycle's inputs.
  task automatic step(input logic rst, input logic r, input logic s, input logic j,
                      input logic [31:0] ja);
    check_eq("mem_req", 32'(mem_req), 32'(exp_req));
    check_eq("mem_address", mem_address, discard ? squash_addr : exp_fetch);
    check_eq("valid", 32'(instruction_valid), 32'(sb.size() != 0));
    check_eq("misaligned", 32'(address_misaligned), 32'(exp_mis));
    if (sb.size() != 0) begin
      check_eq("pc", pc, sb[0].pc);
      check_eq("instruction", instruction, sb[0].instr);
    end

    reset               = rst;
    mem_ready           = r;
    stall               = s;
    jump_branch_enable  = j;
    jump_branch_address = ja;

    if (rst) begin
      sb.delete();
      exp_fetch = 32'h0;
      exp_req   = 1'b0;
      discard   = 1'b0;
      exp_mis   = 1'b0;
    end else if (j) begin
      sb.delete();
      exp_mis = |ja[1:0];
      if (exp_req && !r && !discard) begin
        discard     = 1'b1;
        squash_addr = exp_fetch;
      end else if (discard && r) begin
        discard = 1'b0;
      end
      exp_fetch = {ja[31:2], 2'b00};
      exp_req   = 1'b1;
    end else begin
      exp_mis = 1'b0;
      if (sb.size() != 0 && !s) void'(sb.pop_front());
      if (exp_req && r) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          sb.push_back('{pc: exp_fetch, instr: mem_word(exp_fetch)});
          exp_fetch = exp_fetch + 32'd4;
        end
      end
      exp_req = (sb.size() < 2);
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset               = 1'b1;
    mem_ready           = 1'b0;
    stall               = 1'b0;
    jump_branch_enable  = 1'b0;
    jump_branch_address = 32'h0;
    exp_fetch           = 32'h0;
    squash_addr         = 32'h0;
    exp_req             = 1'b0;
    discard             = 1'b0;
    exp_mis             = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");

    // Zero-wait streaming from reset.
    stream(8);

    // Decode stall: skid fills, requests stop, order preserved on release.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    stream(6);

    // Redirect while a fetch waits for memory.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    stream(4);

    // Two redirects while squashing: only the later target survives.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    stream(4);

    // Misaligned redirect while stalled with output and skid full.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0102);
    stream(4);

    // PC wraps past the top of the address space.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    stream(4);

    // Reset in the middle of an outstanding fetch; late ready must be ignored.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_reset_state("mid");
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    stream(4);

    // Mixed random traffic.
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), $urandom & 32'h0000_0FFF);
    end
    stream(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
